// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared FSM state type and default widths for the memory arbiter
package mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_ADDR_WIDTH = 10;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PW      = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PW-1:0]      i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PW-1:0]      o_idx,
    output logic               o_any
);

    // Distance k from the pointer ranks each requester; the nearest one wins.
    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!o_any && i_req[i] &&
                    ((i + NUM_REQ - int'(i_ptr)) % NUM_REQ) == k) begin
                    o_any      = 1'b1;
                    o_grant[i] = 1'b1;
                    o_idx      = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter serialising NUM_REQ ports onto one memory
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int TIMEOUT    = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_REQ*WIDTH-1:0]      wdata,
    output logic [NUM_REQ-1:0]            done,
    output logic [NUM_REQ-1:0]            err,
    output logic [WIDTH-1:0]              rdata,
    output logic                          busy,
    output logic                          mem_valid,
    output logic                          mem_rw_en,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [WIDTH-1:0]              mem_wdata,
    input  logic                          mem_ready,
    input  logic [WIDTH-1:0]              mem_rdata
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(TIMEOUT + 2);

    state_t              r_state, w_next;
    logic [PW-1:0]       r_ptr, w_idx, w_ptr_next;
    logic [NUM_REQ-1:0]  w_grant, r_grant;
    logic                w_any;
    logic                w_sel_we, r_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr, r_addr;
    logic [WIDTH-1:0]    w_sel_wdata, r_wdata, r_rdata;
    logic [CW-1:0]       r_cnt;
    logic [NUM_REQ-1:0]  r_done, r_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_we    = we[i];
                w_sel_addr  = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                w_sel_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign w_ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_any) w_next = ST_ISSUE;
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT:  if (mem_ready || r_cnt == CW'(TIMEOUT)) w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // done/err are registered so they land in the cycle after the WAIT decision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr   <= '0;
            r_grant <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
        end else begin
            r_done <= '0;
            r_err  <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_grant <= w_grant;
                        r_we    <= w_sel_we;
                        r_addr  <= w_sel_addr;
                        r_wdata <= w_sel_wdata;
                        r_ptr   <= w_ptr_next;
                    end
                end
                ST_ISSUE: r_cnt <= '0;
                ST_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (mem_ready) begin
                        r_done <= r_grant;
                        if (!r_we) r_rdata <= mem_rdata;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_err <= r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_valid = (r_state == ST_ISSUE);
    assign mem_rw_en = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign err       = r_err;
    assign rdata     = r_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - randomized self-checking bench with a transaction-level reference model
module tb_mem_arbiter;

    localparam int N   = 4;
    localparam int W   = 32;
    localparam int AW  = 10;
    localparam int TMO = 15;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req;
    logic [N-1:0]    we;
    logic [N*AW-1:0] addr_bus;
    logic [N*W-1:0]  wdata_bus;
    logic [N-1:0]    done;
    logic [N-1:0]    err;
    logic [W-1:0]    rdata;
    logic            busy;
    logic            mem_valid;
    logic            mem_rw_en;
    logic [AW-1:0]   mem_addr;
    logic [W-1:0]    mem_wdata;
    logic            mem_ready;
    logic [W-1:0]    mem_rdata;

    logic [AW-1:0]   tb_addr  [N];
    logic [W-1:0]    tb_wdata [N];

    // memory device with a preload port and a stall switch
    logic [W-1:0]    mem_dev [1024];
    logic            pl_en;
    logic [AW-1:0]   pl_a;
    logic [W-1:0]    pl_d;
    logic            stall;

    // reference model state
    logic [W-1:0]    ref_mem [1024];
    logic [W-1:0]    m_rdata;
    int              m_ptr;

    int n_checks;
    int n_fail;

    mem_arbiter #(
        .NUM_REQ    (N),
        .WIDTH      (W),
        .ADDR_WIDTH (AW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .addr      (addr_bus),
        .wdata     (wdata_bus),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .busy      (busy),
        .mem_valid (mem_valid),
        .mem_rw_en (mem_rw_en),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_bus[i*AW +: AW] = tb_addr[i];
            wdata_bus[i*W +: W]  = tb_wdata[i];
        end
    end

    always @(posedge clk) begin
        mem_ready <= 1'b0;
        if (pl_en) begin
            mem_dev[pl_a] <= pl_d;
        end else if (mem_valid && !stall) begin
            mem_ready <= 1'b1;
            if (mem_rw_en) mem_dev[mem_addr] <= mem_wdata;
            else           mem_rdata <= mem_dev[mem_addr];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Wait for port p's response from the current negedge, check it, then release its req.
    task automatic serve(input int p, input bit exp_err);
        int n;
        int exp_n;
        exp_n = exp_err ? TMO + 3 : 3;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check_eq("mem_valid_issue", 32'(mem_valid), 32'd1);
                check_eq("mem_addr", 32'(mem_addr), 32'(tb_addr[p]));
                check_eq("mem_rw_en", 32'(mem_rw_en), 32'(we[p]));
                if (we[p]) check_eq("mem_wdata", mem_wdata, tb_wdata[p]);
                check_eq("busy_issue", 32'(busy), 32'd1);
            end else if (n == 2) begin
                check_eq("mem_valid_wait", 32'(mem_valid), 32'd0);
            end else if (done != 0 || err != 0) begin
                // fall through to the response checks below
            end else begin
                check_eq("busy_wait", 32'(busy), 32'd1);
            end
        end while (done == 0 && err == 0 && n < 40);
        check_eq("latency", n, exp_n);
        if (exp_err) begin
            check_eq("err_port", 32'(err), 32'(1 << p));
            check_eq("done_on_err", 32'(done), 32'd0);
        end else begin
            check_eq("done_port", 32'(done), 32'(1 << p));
            check_eq("err_on_done", 32'(err), 32'd0);
            if (we[p]) ref_mem[tb_addr[p]] = tb_wdata[p];
            else       m_rdata = ref_mem[tb_addr[p]];
        end
        check_eq("busy_idle", 32'(busy), 32'd0);
        check_eq("rdata", rdata, m_rdata);
        req[p] = 1'b0;
        m_ptr  = (p + 1) % N;
    endtask

    // Raise all ports in mask together; the model expects service in rotation from m_ptr.
    task automatic run_round(input logic [N-1:0] mask, input bit exp_err);
        int order[$];
        for (int k = 0; k < N; k++)
            if (mask[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
        @(negedge clk);
        req = mask;
        foreach (order[j]) serve(order[j], exp_err);
    endtask

    task automatic set_port(input int p, input logic w, input logic [AW-1:0] a, input logic [W-1:0] d);
        we[p]       = w;
        tb_addr[p]  = a;
        tb_wdata[p] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        req      = '0;
        we       = '0;
        pl_en    = 1'b0;
        pl_a     = '0;
        pl_d     = '0;
        stall    = 1'b0;
        for (int i = 0; i < N; i++) set_port(i, 1'b0, '0, '0);
        for (int i = 0; i < 1024; i++) ref_mem[i] = (i * 32'h0100_0193) ^ 32'hA5A5_0000;
        ref_mem[5] = 32'hDEAD_BEEF;

        for (int i = 0; i < 1024; i++) begin
            @(negedge clk);
            pl_en = 1'b1;
            pl_a  = AW'(i);
            pl_d  = ref_mem[i];
        end
        @(negedge clk);
        pl_en = 1'b0;

        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'd0);
        rst     = 1'b0;
        m_ptr   = 0;
        m_rdata = '0;

        // single read of a preloaded word
        set_port(0, 1'b0, 10'd5, '0);
        run_round(4'b0001, 1'b0);
        check_eq("read_deadbeef", rdata, 32'hDEAD_BEEF);

        // write then read the top address on port 2
        set_port(2, 1'b1, 10'd1023, 32'h1234_5678);
        run_round(4'b0100, 1'b0);
        check_eq("rdata_kept_on_write", rdata, 32'hDEAD_BEEF);
        set_port(2, 1'b0, 10'd1023, '0);
        run_round(4'b0100, 1'b0);
        check_eq("read_back_1023", rdata, 32'h1234_5678);

        // port 3 alone wraps the pointer, then 0 and 3 together
        set_port(3, 1'b0, 10'd9, '0);
        run_round(4'b1000, 1'b0);
        check_eq("ptr_wrapped", m_ptr, 0);
        set_port(0, 1'b0, 10'd10, '0);
        run_round(4'b1001, 1'b0);

        // full contention straight out of reset
        do_reset();
        for (int i = 0; i < N; i++) set_port(i, 1'(i & 1), AW'(100 + i), 32'hC0DE_0000 + i);
        run_round(4'b1111, 1'b0);

        // stalled memory -> timeout on port 1
        stall = 1'b1;
        set_port(1, 1'b0, 10'd77, '0);
        run_round(4'b0010, 1'b1);
        stall = 1'b0;

        // asynchronous reset in the WAIT state
        set_port(0, 1'b0, 10'd7, '0);
        @(negedge clk);
        req = 4'b0001;
        repeat (2) @(negedge clk);
        check_eq("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_mem_valid", 32'(mem_valid), 32'd0);
        check_eq("arst_mem_rw_en", 32'(mem_rw_en), 32'd0);
        check_eq("arst_mem_addr", 32'(mem_addr), 32'd0);
        check_eq("arst_mem_wdata", mem_wdata, 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        check_eq("arst_rdata", rdata, 32'd0);
        req     = '0;
        m_ptr   = 0;
        m_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check_eq("no_done_after_rst", 32'(done | err), 32'd0);
        end
        run_round(4'b0001, 1'b0);

        // randomized rounds
        for (int r = 0; r < 30; r++) begin
            logic [N-1:0] mask;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++)
                set_port(i, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 1023)), $urandom);
            run_round(mask, 1'b0);
        end

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
